// File: rtl/cmd_link_pkg.sv
// cmd_link_pkg -- shared definitions for the command-link initiator.
//   cmd_state_e      : FSM state encoding
//   CMD_OP_WRITE/READ: default opcode bytes
//   is_send_state()  : true for states that launch a byte to the transmitter
package cmd_link_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_SEND_OP   = 4'd1,
    ST_WAIT_OP   = 4'd2,
    ST_SEND_ADDR = 4'd3,
    ST_WAIT_ADDR = 4'd4,
    ST_SEND_DATA = 4'd5,
    ST_WAIT_DATA = 4'd6,
    ST_WAIT_RSP  = 4'd7,
    ST_DONE      = 4'd8
  } cmd_state_e;

  localparam logic [7:0] CMD_OP_WRITE     = 8'h57;
  localparam logic [7:0] CMD_OP_READ      = 8'h52;
  localparam logic [7:0] RSP_DATA_WRITE   = 8'h00;
  localparam logic [7:0] RSP_DATA_TIMEOUT = 8'hFF;

  function automatic logic is_send_state(input cmd_state_e s);
    logic r;
    case (s)
      ST_SEND_OP, ST_SEND_ADDR, ST_SEND_DATA: r = 1'b1;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmd_link_timer.sv
// cmd_link_timer -- reply timeout counter (present only with CMD_LINK_TIMEOUT_EN).
//   clk, rst : clock, asynchronous active-high reset
//   clear    : forces the count back to zero (dominates enable)
//   enable   : counts one per cycle while high
//   expired  : high in the cycle the count reaches TIMEOUT_CYCLES-1
`ifdef CMD_LINK_TIMEOUT_EN
module cmd_link_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins; the count parks at its last value instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (enable && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && !clear && (cnt_q == CNT_LAST);

endmodule
`endif

// File: rtl/cmd_link_initiator.sv
// cmd_link_initiator -- turns a request (write or read) into opcode/address/data
// bytes for a serial transmitter and returns a one-cycle response.
//   CLK_50MHZ, RST            : clock, asynchronous active-high reset
//   REQ_VALID/READY/WR/ADDR/DATA : request handshake and payload
//   RSP_VALID/DATA/TIMEOUT    : response pulse, read data, no-reply flag
//   TX_DATA/TX_TRG/TX_DONE    : byte transmitter interface
//   RX_DATA/RX_DONE           : byte receiver interface
// Build option CMD_LINK_TIMEOUT_EN: adds the reply timeout (cmd_link_timer).
// Without it a read waits for a reply forever and RSP_TIMEOUT stays 0.
module cmd_link_initiator
  import cmd_link_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd5000000,
  parameter logic [7:0]  OP_WRITE       = CMD_OP_WRITE,
  parameter logic [7:0]  OP_READ        = CMD_OP_READ
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_WR,
  input  logic [7:0] REQ_ADDR,
  input  logic [7:0] REQ_DATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       RSP_TIMEOUT,
  output logic [7:0] TX_DATA,
  output logic       TX_TRG,
  input  logic       TX_DONE,
  input  logic [7:0] RX_DATA,
  input  logic       RX_DONE
);

  cmd_state_e state_q, state_d;
  logic       wr_q, wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       req_ready_q, req_ready_d;
  logic       tx_trg_q, tx_trg_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_timeout_q, rsp_timeout_d;
  logic       accept_s;
  logic       timer_expired_s;

`ifdef CMD_LINK_TIMEOUT_EN
  cmd_link_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (CLK_50MHZ),
    .rst     (RST),
    .clear   (state_q != ST_WAIT_RSP),
    .enable  (state_q == ST_WAIT_RSP),
    .expired (timer_expired_s)
  );
`else
  // No timer: never expires. TIMEOUT_CYCLES stays referenced so both builds share one interface.
  assign timer_expired_s = (TIMEOUT_CYCLES == 32'd0) & 1'b0;
`endif

  // REQ_READY is registered and high exactly in IDLE, so this is the accept condition.
  assign accept_s = REQ_VALID && req_ready_q;

  // Next-state, request capture and next values of all registered outputs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (accept_s) state_d = ST_SEND_OP;   else state_d = ST_IDLE;
      ST_SEND_OP:   state_d = ST_WAIT_OP;
      ST_WAIT_OP:   if (TX_DONE)  state_d = ST_SEND_ADDR; else state_d = ST_WAIT_OP;
      ST_SEND_ADDR: state_d = ST_WAIT_ADDR;
      ST_WAIT_ADDR: if (TX_DONE)  state_d = wr_q ? ST_SEND_DATA : ST_WAIT_RSP;
                    else          state_d = ST_WAIT_ADDR;
      ST_SEND_DATA: state_d = ST_WAIT_DATA;
      ST_WAIT_DATA: if (TX_DONE)  state_d = ST_DONE;      else state_d = ST_WAIT_DATA;
      ST_WAIT_RSP:  if (RX_DONE || timer_expired_s) state_d = ST_DONE;
                    else          state_d = ST_WAIT_RSP;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    if (accept_s) begin
      wr_d   = REQ_WR;
      addr_d = REQ_ADDR;
      data_d = REQ_DATA;
    end else begin
      wr_d   = wr_q;
      addr_d = addr_q;
      data_d = data_q;
    end

    req_ready_d = (state_d == ST_IDLE);
    tx_trg_d    = is_send_state(state_d);
    rsp_valid_d = (state_d == ST_DONE);

    // The byte is loaded on entry to a SEND state and then held until the next SEND.
    case (state_d)
      ST_SEND_OP:   tx_data_d = wr_d ? OP_WRITE : OP_READ;
      ST_SEND_ADDR: tx_data_d = addr_d;
      ST_SEND_DATA: tx_data_d = data_d;
      default:      tx_data_d = tx_data_q;
    endcase

    // Response payload only changes on the transition into DONE; a reply byte beats
    // a same-cycle timeout, and RX_DONE elsewhere never touches it.
    if ((state_q == ST_WAIT_RSP) && RX_DONE) begin
      rsp_data_d = RX_DATA;
    end else if ((state_q == ST_WAIT_RSP) && timer_expired_s) begin
      rsp_data_d = RSP_DATA_TIMEOUT;
    end else if ((state_q == ST_WAIT_DATA) && TX_DONE) begin
      rsp_data_d = RSP_DATA_WRITE;
    end else begin
      rsp_data_d = rsp_data_q;
    end

    rsp_timeout_d = (state_q == ST_WAIT_RSP) && !RX_DONE && timer_expired_s;
  end

  // FSM state, captured request and registered outputs.
  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      wr_q          <= 1'b0;
      addr_q        <= 8'h00;
      data_q        <= 8'h00;
      req_ready_q   <= 1'b1;
      tx_trg_q      <= 1'b0;
      tx_data_q     <= 8'h00;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 8'h00;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      req_ready_q   <= req_ready_d;
      tx_trg_q      <= tx_trg_d;
      tx_data_q     <= tx_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign REQ_READY   = req_ready_q;
  assign TX_TRG      = tx_trg_q;
  assign TX_DATA     = tx_data_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_DATA    = rsp_data_q;
  assign RSP_TIMEOUT = rsp_timeout_q;

endmodule

// File: tb/tb_cmd_link_initiator.sv
// Self-checking bench for cmd_link_initiator. Each request is planned as a
// timeline (when each byte is triggered, when TX_DONE/RX_DONE come back, when the
// response is due); a per-cycle monitor checks the DUT against that timeline.
module tb_cmd_link_initiator;

  localparam int T = 16;
`ifdef CMD_LINK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0, req_wr = 1'b0, tx_done = 1'b0, rx_done = 1'b0;
  logic [7:0] req_addr = 8'h00, req_data = 8'h00, rx_data = 8'h00;
  logic       req_ready, rsp_valid, rsp_timeout, tx_trg;
  logic [7:0] rsp_data, tx_data;

  cmd_link_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .CLK_50MHZ(clk), .RST(rst),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WR(req_wr),
    .REQ_ADDR(req_addr), .REQ_DATA(req_data),
    .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data), .RSP_TIMEOUT(rsp_timeout),
    .TX_DATA(tx_data), .TX_TRG(tx_trg), .TX_DONE(tx_done),
    .RX_DATA(rx_data), .RX_DONE(rx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected timeline, keyed by cycle number.
  logic [7:0] exp_trg  [int];
  logic [7:0] exp_txd  [int];
  logic [8:0] exp_rsp  [int];
  bit         exp_busy [int];

  // Observations for the hand-computed directed checks.
  logic [7:0] obs_tx [$];
  int         rsp_cnt = 0;
  int         last_rsp_cyc = 0;
  logic [7:0] last_rsp_data = 8'h00;
  logic       last_rsp_to = 1'b0;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the planned timeline.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("tx_trg", tx_trg, exp_trg.exists(cyc));
      if (tx_trg) obs_tx.push_back(tx_data);
      if (exp_txd.exists(cyc)) chk("tx_data", tx_data, exp_txd[cyc]);
      chk("rsp_valid", rsp_valid, exp_rsp.exists(cyc));
      if (rsp_valid) begin
        rsp_cnt++;
        last_rsp_cyc  = cyc;
        last_rsp_data = rsp_data;
        last_rsp_to   = rsp_timeout;
        if (exp_rsp.exists(cyc)) begin
          chk("rsp_data", rsp_data, exp_rsp[cyc][7:0]);
          chk("rsp_timeout", rsp_timeout, exp_rsp[cyc][8]);
        end
      end
      chk("req_ready", req_ready, !exp_busy.exists(cyc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one request. d1..d3: cycles from each TX_TRG to its TX_DONE; r: cycles from
  // entering the reply wait to RX_DONE; stray_off >= 0 injects RX_DONE=77 at accept+off.
  task automatic run_txn(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                         input int d1, input int d2, input int d3, input int r,
                         input int gap, input bit noreply, input logic [7:0] rxd,
                         input int stray_off, input bit rnd, output int acc, output int wst);
    int a, b, c, dn, rxc;
    logic [7:0] op;
    bit in_wait;
    for (int i = 0; i < gap; i++) begin
      req_valid = 1'b0;
      step();
    end
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_data = data;
    a  = cyc + 1;
    op = wr ? 8'h57 : 8'h52;
    b  = a + d1 + 1;
    c  = b + d2 + 1;
    rxc = -1;
    if (wr)           dn = c + d3 + 1;
    else if (noreply) dn = c + T;
    else begin
      rxc = c + r;
      dn  = c + r + 1;
    end
    exp_trg[a] = op;
    for (int k = a; k <= a + d1; k++) exp_txd[k] = op;
    exp_trg[b] = addr;
    for (int k = b; k <= b + d2; k++) exp_txd[k] = addr;
    if (wr) begin
      exp_trg[c] = data;
      for (int k = c; k <= c + d3; k++) exp_txd[k] = data;
    end
    exp_rsp[dn] = wr ? {1'b0, 8'h00} : (noreply ? {1'b1, 8'hFF} : {1'b0, rxd});
    for (int k = a; k <= dn; k++) exp_busy[k] = 1'b1;
    for (int k = a; k <= dn; k++) begin
      step();
      tx_done = (k == a + d1) || (k == b + d2) || (wr && (k == c + d3));
      rx_done = 1'b0;
      rx_data = 8'($urandom);
      if (k == rxc) begin
        rx_done = 1'b1; rx_data = rxd;
      end else if ((stray_off >= 0) && (k == a + stray_off)) begin
        rx_done = 1'b1; rx_data = 8'h77;
      end
      if (rnd) begin
        req_valid = 1'($urandom_range(0, 1));
        req_wr    = 1'($urandom_range(0, 1));
        req_addr  = 8'($urandom);
        req_data  = 8'($urandom);
        in_wait = ((k > a) && (k <= a + d1)) || ((k > b) && (k <= b + d2)) ||
                  (wr && (k > c) && (k <= c + d3));
        if (!tx_done && !in_wait && ($urandom_range(0, 3) == 0)) tx_done = 1'b1;
        if (!rx_done && !(!wr && (k >= c) && (k < dn)) && ($urandom_range(0, 3) == 0))
          rx_done = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
    end
    step();
    req_valid = 1'b0; tx_done = 1'b0; rx_done = 1'b0;
    acc = a;
    wst = c;
  endtask

  task automatic check_bytes(input string nm, input int n, input logic [23:0] bytes);
    logic [23:0] bv;
    bv = bytes;
    chk({nm, "_count"}, obs_tx.size(), n);
    for (int i = 0; i < n; i++)
      chk({nm, "_byte"}, (i < obs_tx.size()) ? 32'(obs_tx[i]) : 32'hDEAD,
          32'(bv[8*(n-1-i) +: 8]));
  endtask

  // Reset pulsed while the address byte is in flight; no response may follow.
  task automatic reset_mid();
    int a, n0;
    n0 = rsp_cnt;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h5A; req_data = 8'hC3;
    a = cyc + 1;
    exp_trg[a] = 8'h57; exp_txd[a] = 8'h57; exp_txd[a+1] = 8'h57;
    exp_trg[a+2] = 8'h5A; exp_txd[a+2] = 8'h5A;
    for (int k = a; k <= a + 2; k++) exp_busy[k] = 1'b1;
    step(); req_valid = 1'b0; tx_done = 1'b0;
    step(); tx_done = 1'b1;
    step(); tx_done = 1'b0;
    step();
    #1 rst = 1'b1;
    #1;
    chk("midrst_ready", req_ready, 1'b1);
    chk("midrst_tx_trg", tx_trg, 1'b0);
    chk("midrst_tx_data", tx_data, 8'h00);
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    step(); rst = 1'b0;
    step(); step();
    chk("midrst_no_rsp", rsp_cnt, n0);
  endtask

  initial begin
    int acc, wst, n0, r;
    bit wr, nr;
    step(); step();
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_tx_trg", tx_trg, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_rsp_timeout", rsp_timeout, 1'b0);
    mon_en = 1'b1;
    step(); rst = 1'b0;

    // Write 12 <- A5 with immediate TX_DONEs: six cycles accept to response.
    obs_tx.delete(); n0 = rsp_cnt;
    run_txn(1'b1, 8'h12, 8'hA5, 1, 1, 1, 0, 1, 1'b0, 8'h00, -1, 1'b0, acc, wst);
    check_bytes("wr", 3, 24'h5712A5);
    chk("wr_rsp_count", rsp_cnt - n0, 1);
    chk("wr_latency", last_rsp_cyc - acc, 6);
    chk("wr_rsp_data", last_rsp_data, 8'h00);
    chk("wr_rsp_timeout", last_rsp_to, 1'b0);

    // Read 03, reply 3C five cycles after the address TX_DONE.
    obs_tx.delete(); n0 = rsp_cnt;
    run_txn(1'b0, 8'h03, 8'h00, 1, 1, 1, 4, 1, 1'b0, 8'h3C, -1, 1'b0, acc, wst);
    check_bytes("rd", 2, 24'h005203);
    chk("rd_rsp_count", rsp_cnt - n0, 1);
    chk("rd_rsp_data", last_rsp_data, 8'h3C);
    chk("rd_rsp_timeout", last_rsp_to, 1'b0);

    // Stray 77 during the opcode wait, then the real reply 42.
    run_txn(1'b0, 8'h44, 8'h00, 2, 1, 1, 2, 0, 1'b0, 8'h42, 1, 1'b0, acc, wst);
    chk("stray_rsp_data", last_rsp_data, 8'h42);

`ifdef CMD_LINK_TIMEOUT_EN
    // No reply: timeout response 16 cycles after entering the reply wait.
    run_txn(1'b0, 8'h10, 8'h00, 1, 1, 1, 0, 1, 1'b1, 8'h00, -1, 1'b0, acc, wst);
    chk("to_latency", last_rsp_cyc - wst, 16);
    chk("to_rsp_data", last_rsp_data, 8'hFF);
    chk("to_rsp_timeout", last_rsp_to, 1'b1);
    // Reply coincident with expiry: data wins.
    run_txn(1'b0, 8'h11, 8'h00, 1, 1, 1, T - 1, 1, 1'b0, 8'h99, -1, 1'b0, acc, wst);
    chk("tie_latency", last_rsp_cyc - wst, 16);
    chk("tie_rsp_data", last_rsp_data, 8'h99);
    chk("tie_rsp_timeout", last_rsp_to, 1'b0);
`endif

    // Reset in the address wait, then a normal write.
    reset_mid();
    obs_tx.delete(); n0 = rsp_cnt;
    run_txn(1'b1, 8'h21, 8'h9E, 1, 2, 1, 0, 0, 1'b0, 8'h00, -1, 1'b0, acc, wst);
    check_bytes("post_rst", 3, 24'h57219E);
    chk("post_rst_rsp_count", rsp_cnt - n0, 1);

    // Randomized traffic with stray strobes and busy-time REQ_VALID noise.
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      nr = TO_EN && !wr && ($urandom_range(0, 4) == 0);
      r  = TO_EN ? int'($urandom_range(0, T - 1)) : int'($urandom_range(0, 20));
      run_txn(wr, 8'($urandom), 8'($urandom),
              int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
              int'($urandom_range(1, 4)), r, int'($urandom_range(0, 2)),
              nr, 8'($urandom), -1, 1'b1, acc, wst);
    end

    step(); step();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
